// File: rtl/reduce_nway_pipe_pkg.sv
// rtl/reduce_nway_pipe_pkg.sv - operator encoding and padding helper for the N-way reduction pipe
package reduce_nway_pipe_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  // Identity bit used to pad unused tree lanes: all-ones for AND, zero otherwise.
  function automatic logic pad_bit(op_e op);
    return op == OP_AND;
  endfunction

endpackage

// File: rtl/reduce_nway_pipe_if.sv
// rtl/reduce_nway_pipe_if.sv - valid/ready stream and status bundle for the reduction pipe
interface reduce_nway_pipe_if
  import reduce_nway_pipe_pkg::*;
#(
  parameter int N_INPUTS = 8,
  parameter int WIDTH    = 1
);
  logic                      in_valid;
  logic                      in_ready;
  logic [N_INPUTS*WIDTH-1:0] in_data;
  op_e                       in_op;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic                      clear_any;
  logic                      any_seen;

  modport master (
    output in_valid, in_data, in_op, out_ready, clear_any,
    input  in_ready, out_valid, out_data, any_seen
  );

  modport slave (
    input  in_valid, in_data, in_op, out_ready, clear_any,
    output in_ready, out_valid, out_data, any_seen
  );
endinterface

// File: rtl/reduce_nway_pipe_node.sv
// rtl/reduce_nway_pipe_node.sv - two-input combinational combiner for one tree lane
module reduce_nway_pipe_node
  import reduce_nway_pipe_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  // NOR combines as OR inside the tree; inversion happens once at the output.
  always_comb begin
    case (op)
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      default: y = a | b;
    endcase
  end
endmodule

// File: rtl/reduce_nway_pipe.sv
// rtl/reduce_nway_pipe.sv - pipelined N-way bitwise reduction tree with valid/ready and sticky status
module reduce_nway_pipe
  import reduce_nway_pipe_pkg::*;
#(
  parameter int N_INPUTS = 8,
  parameter int WIDTH    = 1
) (
  input logic              clk,
  input logic              reset,
  reduce_nway_pipe_if.slave bus
);
  localparam int STAGES = $clog2(N_INPUTS);
  localparam int PADDED = 1 << STAGES;

  logic                    advance;
  logic                    accept;
  logic [STAGES-1:0]       vld_d, vld_q;
  op_e                     op_d [STAGES];
  op_e                     op_q [STAGES];
  logic [PADDED*WIDTH-1:0] lvl0;
  logic                    any_d, any_q;

  // Whole-pipe stall: every stage moves together or none does.
  assign advance      = bus.out_ready | ~vld_q[STAGES-1];
  assign accept       = bus.in_valid & advance;
  assign bus.in_ready = advance;

  if (PADDED > N_INPUTS) begin : g_pad
    assign lvl0 = {{((PADDED - N_INPUTS) * WIDTH){pad_bit(bus.in_op)}}, bus.in_data};
  end else begin : g_nopad
    assign lvl0 = bus.in_data;
  end

  always_comb begin
    vld_d = vld_q;
    for (int s = 0; s < STAGES; s++) op_d[s] = op_q[s];
    if (advance) begin
      vld_d[0] = bus.in_valid;
      op_d[0]  = accept ? bus.in_op : op_q[0];
      for (int s = 1; s < STAGES; s++) begin
        vld_d[s] = vld_q[s-1];
        op_d[s]  = op_q[s-1];
      end
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_lvl
    localparam int LANES = PADDED >> (s + 1);
    logic [2*LANES*WIDTH-1:0] src;
    logic [LANES*WIDTH-1:0]   comb;
    logic [LANES*WIDTH-1:0]   dat_d, dat_q;
    op_e                      src_op;

    if (s == 0) begin : g_src
      assign src    = lvl0;
      assign src_op = bus.in_op;
    end else begin : g_src
      assign src    = g_lvl[s-1].dat_q;
      assign src_op = op_q[s-1];
    end

    for (genvar k = 0; k < LANES; k++) begin : g_node
      reduce_nway_pipe_node #(.WIDTH(WIDTH)) u_node (
        .op (src_op),
        .a  (src[(2*k)*WIDTH +: WIDTH]),
        .b  (src[(2*k+1)*WIDTH +: WIDTH]),
        .y  (comb[k*WIDTH +: WIDTH])
      );
    end

    always_comb begin
      dat_d = dat_q;
      if (advance) dat_d = comb;
    end

    always_ff @(posedge clk) begin
      if (reset) dat_q <= '0;
      else       dat_q <= dat_d;
    end
  end

  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.out_data  = (op_q[STAGES-1] == OP_NOR) ? ~g_lvl[STAGES-1].dat_q
                                                    :  g_lvl[STAGES-1].dat_q;

  // A set event in the same cycle as clear_any takes priority.
  always_comb begin
    any_d = any_q;
    if (bus.clear_any) any_d = 1'b0;
    if (bus.out_valid && bus.out_ready && (|bus.out_data)) any_d = 1'b1;
  end
  assign bus.any_seen = any_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int s = 0; s < STAGES; s++) op_q[s] <= OP_OR;
      any_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      for (int s = 0; s < STAGES; s++) op_q[s] <= op_d[s];
      any_q <= any_d;
    end
  end
endmodule

// File: tb/tb_reduce_nway_pipe.sv
// tb/tb_reduce_nway_pipe.sv - directed self-checking bench for reduce_nway_pipe (N=8/W=1 and N=5/W=4)
module tb_reduce_nway_pipe;
  import reduce_nway_pipe_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  reduce_nway_pipe_if #(.N_INPUTS(8), .WIDTH(1)) b8 ();
  reduce_nway_pipe_if #(.N_INPUTS(5), .WIDTH(4)) b5 ();

  reduce_nway_pipe #(.N_INPUTS(8), .WIDTH(1)) u8 (.clk(clk), .reset(reset), .bus(b8));
  reduce_nway_pipe #(.N_INPUTS(5), .WIDTH(4)) u5 (.clk(clk), .reset(reset), .bus(b5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset held 3 cycles with beats offered on both instances
    reset = 1'b1;
    b8.in_valid = 1'b1; b8.in_data = 8'hFF;     b8.in_op = OP_OR;
    b8.out_ready = 1'b1; b8.clear_any = 1'b0;
    b5.in_valid = 1'b1; b5.in_data = 20'hFFFFF; b5.in_op = OP_OR;
    b5.out_ready = 1'b1; b5.clear_any = 1'b0;
    repeat (3) tick();
    chk("rst8_valid", b8.out_valid, 0);
    chk("rst8_data",  b8.out_data,  0);
    chk("rst8_any",   b8.any_seen,  0);
    chk("rst5_valid", b5.out_valid, 0);
    chk("rst5_data",  b5.out_data,  0);
    chk("rst5_any",   b5.any_seen,  0);
    reset = 1'b0;
    b8.in_valid = 1'b0;
    b5.in_valid = 1'b0;

    // Legacy 8-way OR, latency 3
    b8.in_valid = 1'b1; b8.in_data = 8'b0001_0000;
    tick();
    b8.in_data = 8'h00;
    tick();
    b8.in_valid = 1'b0;
    chk("or8_not_yet", b8.out_valid, 0);
    tick();
    chk("or8_v1",  b8.out_valid, 1);
    chk("or8_d1",  b8.out_data,  1);
    tick();
    chk("or8_v0",  b8.out_valid, 1);
    chk("or8_d0",  b8.out_data,  0);
    chk("or8_any", b8.any_seen,  1);
    tick();
    chk("or8_idle", b8.out_valid, 0);

    // N=5, W=4: AND / XOR / NOR with identity padding
    b5.in_valid = 1'b1; b5.in_op = OP_AND; b5.in_data = 20'hFF7FF;
    tick();
    b5.in_op = OP_XOR; b5.in_data = 20'h18421;
    tick();
    b5.in_op = OP_NOR; b5.in_data = 20'h00000;
    tick();
    b5.in_valid = 1'b0; b5.in_op = OP_AND;
    chk("and5", b5.out_data, 4'h7);
    tick();
    chk("xor5", b5.out_data, 4'hE);
    tick();
    chk("nor5_v", b5.out_valid, 1);
    chk("nor5",   b5.out_data,  4'hF);
    tick();
    chk("n5_idle", b5.out_valid, 0);

    // Back-to-back 4 beats with a 2-cycle downstream stall
    b5.in_op = OP_OR; b5.in_valid = 1'b1; b5.in_data = 20'h00001;
    tick();
    b5.in_data = 20'h00002;
    tick();
    b5.in_data = 20'h00003;
    tick();
    chk("b2b_o1", b5.out_data, 4'h1);
    b5.in_data = 20'h00004;
    tick();
    b5.in_valid = 1'b0;
    chk("b2b_o2", b5.out_data, 4'h2);
    b5.out_ready = 1'b0;
    #1;
    chk("stall_rdy_a", b5.in_ready, 0);
    tick();
    chk("stall_v",     b5.out_valid, 1);
    chk("stall_d_a",   b5.out_data,  4'h2);
    chk("stall_rdy_b", b5.in_ready,  0);
    tick();
    chk("stall_d_b",   b5.out_data,  4'h2);
    b5.out_ready = 1'b1;
    #1;
    chk("stall_rdy_c", b5.in_ready, 1);
    tick();
    chk("b2b_o3", b5.out_data, 4'h3);
    tick();
    chk("b2b_o4_v", b5.out_valid, 1);
    chk("b2b_o4",   b5.out_data,  4'h4);
    tick();
    chk("b2b_done", b5.out_valid, 0);

    // Sticky any_seen
    b5.clear_any = 1'b1;
    tick();
    b5.clear_any = 1'b0;
    chk("any_cleared", b5.any_seen, 0);
    b5.in_valid = 1'b1; b5.in_data = 20'h00000;
    tick();
    b5.in_data = 20'h00200;
    tick();
    b5.in_data = 20'h00000;
    tick();
    b5.in_valid = 1'b0;
    chk("any_z1", b5.any_seen, 0);
    tick();
    chk("any_d2",   b5.out_data, 4'h2);
    chk("any_pre",  b5.any_seen, 0);
    tick();
    chk("any_set",  b5.any_seen, 1);
    tick();
    chk("any_hold", b5.any_seen, 1);
    b5.in_valid = 1'b1; b5.in_data = 20'h00002;
    tick();
    b5.in_valid = 1'b0;
    tick();
    tick();
    chk("coinc_d", b5.out_data, 4'h2);
    b5.clear_any = 1'b1;
    tick();
    b5.clear_any = 1'b0;
    chk("any_set_wins", b5.any_seen, 1);
    b5.clear_any = 1'b1;
    tick();
    b5.clear_any = 1'b0;
    chk("any_lone_clear", b5.any_seen, 0);

    // Reset with 2 beats in flight
    b5.in_valid = 1'b1; b5.in_data = 20'h00005;
    tick();
    b5.in_data = 20'h00006;
    tick();
    b5.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("flush_d", b5.out_data, 0);
    for (int i = 0; i < 4; i++) begin
      chk("flush_v", b5.out_valid, 0);
      tick();
    end
    b5.in_valid = 1'b1; b5.in_op = OP_XOR; b5.in_data = 20'h00093;
    tick();
    b5.in_valid = 1'b0;
    tick();
    chk("post_rst_early", b5.out_valid, 0);
    tick();
    chk("post_rst_v", b5.out_valid, 1);
    chk("post_rst_d", b5.out_data,  4'hA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
